// File: rtl/fetch_sequencer.sv
// fetch_sequencer: fetch-side pipeline control for the vector ASIP.
// Drives the PC enable, the IF/ID enable and flush, and the ID/EX bubble.
// It sequences taken-branch flushes, load-use stalls, vector-op occupancy
// and HALT/RESUME.
//
// Ports:
//   CLK, RESET (sync, active-high)
//   PC_SRC, LOAD_USE, VEC_START, HALT_INS, RESUME : decode/ctrl events
//   PC_EN, IF_ID_EN, IF_ID_FLUSH, ID_EX_BUBBLE    : pipeline controls
//   STATE                                         : current state code
//   STALL_CNT, FLUSH_CNT                          : perf counters
//
// Optional feature: define FETCH_SEQ_PERF_EN to build the perf counters.
// When it is undefined, both counter ports read 16'd0 and no counter
// flops exist.
module fetch_sequencer #(
  parameter int FLUSH_CYCLES = 1,
  parameter int VEC_CYCLES   = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        PC_SRC,
  input  logic        LOAD_USE,
  input  logic        VEC_START,
  input  logic        HALT_INS,
  input  logic        RESUME,
  output logic        PC_EN,
  output logic        IF_ID_EN,
  output logic        IF_ID_FLUSH,
  output logic        ID_EX_BUBBLE,
  output logic [2:0]  STATE,
  output logic [15:0] STALL_CNT,
  output logic [15:0] FLUSH_CNT
);

  localparam logic [2:0] S_RUN   = 3'd0;
  localparam logic [2:0] S_STALL = 3'd1;
  localparam logic [2:0] S_FLUSH = 3'd2;
  localparam logic [2:0] S_VEC   = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;

  // The PC_SRC/VEC_START cycle is the first of the sequence. CNT therefore
  // starts at N-2, and the last extra cycle runs with CNT=0.
  localparam logic [3:0] FLUSH_INIT =
    (FLUSH_CYCLES > 1) ? 4'(FLUSH_CYCLES - 2) : 4'd0;
  localparam logic [3:0] VEC_INIT =
    (VEC_CYCLES > 1) ? 4'(VEC_CYCLES - 2) : 4'd0;
  localparam logic FLUSH_MULTI = (FLUSH_CYCLES > 1);
  localparam logic VEC_MULTI   = (VEC_CYCLES > 1);

  logic [2:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic pc_en, ifid_en, ifid_flush, bubble;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_RUN;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = S_RUN;
    cnt_d      = 4'd0;
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    ifid_flush = 1'b0;
    bubble     = 1'b0;
    case (state_q)
      S_RUN: begin
        // Fixed priority: only the winning event acts.
        if (PC_SRC) begin
          ifid_flush = 1'b1;
          if (FLUSH_MULTI) begin
            state_d = S_FLUSH;
            cnt_d   = FLUSH_INIT;
          end
        end else if (HALT_INS) begin
          pc_en   = 1'b0;
          ifid_en = 1'b0;
          bubble  = 1'b1;
          state_d = S_HALT;
        end else if (LOAD_USE) begin
          pc_en   = 1'b0;
          ifid_en = 1'b0;
          bubble  = 1'b1;
          state_d = S_STALL;
        end else if (VEC_START) begin
          if (VEC_MULTI) begin
            state_d = S_VEC;
            cnt_d   = VEC_INIT;
          end
        end
      end
      S_STALL: begin
        state_d = S_RUN;
      end
      S_FLUSH: begin
        ifid_flush = 1'b1;
        if (cnt_q != 4'd0) begin
          state_d = S_FLUSH;
          cnt_d   = cnt_q - 4'd1;
        end
      end
      S_VEC: begin
        pc_en   = 1'b0;
        ifid_en = 1'b0;
        bubble  = 1'b1;
        if (cnt_q != 4'd0) begin
          state_d = S_VEC;
          cnt_d   = cnt_q - 4'd1;
        end
      end
      S_HALT: begin
        pc_en   = 1'b0;
        ifid_en = 1'b0;
        bubble  = 1'b1;
        state_d = RESUME ? S_RUN : S_HALT;
      end
      default: begin
        // Illegal codes behave as RUN with no event and return to RUN.
        state_d = S_RUN;
      end
    endcase
    if (RESET) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      ifid_flush = 1'b1;
      bubble     = 1'b1;
    end
  end

  assign PC_EN        = pc_en;
  assign IF_ID_EN     = ifid_en;
  assign IF_ID_FLUSH  = ifid_flush;
  assign ID_EX_BUBBLE = bubble;
  assign STATE        = state_q;

`ifdef FETCH_SEQ_PERF_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_en && stall_cnt_q != 16'hFFFF)
      stall_cnt_d = stall_cnt_q + 16'd1;
    if (ifid_flush && flush_cnt_q != 16'hFFFF)
      flush_cnt_d = flush_cnt_q + 16'd1;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign STALL_CNT = stall_cnt_q;
  assign FLUSH_CNT = flush_cnt_q;
`else
  assign STALL_CNT = 16'd0;
  assign FLUSH_CNT = 16'd0;
`endif

endmodule
